// File: rtl/cnn_fp_pkg.sv
// Shared float helpers for the CNN output stages: field widths, canonical qNaN and the rank key
// that orders exp() results (negatives and NaN collapse to zero).
package cnn_fp_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_MAN_W;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;

    typedef enum logic {
        StAccum,
        StDone
    } argmax_state_e;

    // Magnitude bits double as an unsigned ordering key for non-negative floats, +Inf on top.
    function automatic logic [FP_W-2:0] fp_rank(input logic [FP_W-1:0] word);
        logic is_nan;
        is_nan = (&word[FP_W-2:FP_MAN_W]) & (|word[FP_MAN_W-1:0]);
        return (word[FP_W-1] | is_nan) ? '0 : word[FP_W-2:0];
    endfunction

endpackage

// File: rtl/exp_argmax_classifier_if.sv
// Stream interface of exp_argmax_classifier: input beats and the classified result.
// Runner-up signals are present only when EXP_ARGMAX_TOP2_EN is defined.
interface exp_argmax_classifier_if #(
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned MANTISSA_WIDTH = 23,
    parameter int unsigned NUM_CLASSES    = 10
);
    localparam int unsigned W     = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;
    localparam int unsigned IDX_W = $clog2(NUM_CLASSES);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_value;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_class;
    logic [W-1:0]     out_value;
`ifdef EXP_ARGMAX_TOP2_EN
    logic [IDX_W-1:0] out_class2;
    logic [W-1:0]     out_value2;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_class, out_value, out_class2, out_value2
    );
    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_class, out_value, out_class2, out_value2
    );
`else
    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_class, out_value
    );
    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_class, out_value
    );
`endif

endinterface

// File: rtl/fp_rank_key.sv
// Combinational float word -> unsigned rank key; sign and NaN map to zero.
module fp_rank_key
    import cnn_fp_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH = FP_EXP_W,
    parameter int unsigned MANTISSA_WIDTH = FP_MAN_W
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   word_i,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] rank_o
);
    localparam int unsigned W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;

    logic is_nan;

    always_comb begin
        is_nan = (&word_i[W-2:MANTISSA_WIDTH]) & (|word_i[MANTISSA_WIDTH-1:0]);
        rank_o = (word_i[W-1] | is_nan) ? '0 : word_i[W-2:0];
    end

endmodule

// File: rtl/exp_argmax_classifier.sv
// Argmax over a frame of NUM_CLASSES exp() words; emits {index, word} of the largest.
// Define EXP_ARGMAX_TOP2_EN to also track and emit the runner-up.
module exp_argmax_classifier
    import cnn_fp_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH = FP_EXP_W,
    parameter int unsigned MANTISSA_WIDTH = FP_MAN_W,
    parameter int unsigned NUM_CLASSES    = 10
) (
    input logic clk,
    input logic rst_n,
    exp_argmax_classifier_if.slave bus
);
    localparam int unsigned W     = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;
    localparam int unsigned RW    = W - 1;
    localparam int unsigned IDX_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_e    state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [W-1:0]     best_val_q, best_val_d;
    logic [RW-1:0]    best_rank_q, best_rank_d;
    logic [RW-1:0]    in_rank;
    logic             beat;

`ifdef EXP_ARGMAX_TOP2_EN
    logic [IDX_W-1:0] second_idx_q, second_idx_d;
    logic [W-1:0]     second_val_q, second_val_d;
    logic [RW-1:0]    second_rank_q, second_rank_d;
    logic             second_seeded_q, second_seeded_d;
`endif

    fp_rank_key #(
        .EXPONENT_WIDTH(EXPONENT_WIDTH),
        .MANTISSA_WIDTH(MANTISSA_WIDTH)
    ) u_in_rank (
        .word_i(bus.in_value),
        .rank_o(in_rank)
    );

    // in_ready is registered so it stays low throughout reset and rises one cycle after.
    assign beat = bus.in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        best_rank_d = best_rank_q;
`ifdef EXP_ARGMAX_TOP2_EN
        second_idx_d    = second_idx_q;
        second_val_d    = second_val_q;
        second_rank_d   = second_rank_q;
        second_seeded_d = second_seeded_q;
`endif
        unique case (state_q)
            StAccum: begin
                if (beat) begin
                    count_d = count_q + 1'b1;
                    if (count_q == '0) begin
                        best_idx_d  = '0;
                        best_val_d  = bus.in_value;
                        best_rank_d = in_rank;
`ifdef EXP_ARGMAX_TOP2_EN
                        second_seeded_d = 1'b0;
`endif
                    end else if (in_rank > best_rank_q) begin
                        best_idx_d  = count_q;
                        best_val_d  = bus.in_value;
                        best_rank_d = in_rank;
`ifdef EXP_ARGMAX_TOP2_EN
                        second_idx_d    = best_idx_q;
                        second_val_d    = best_val_q;
                        second_rank_d   = best_rank_q;
                        second_seeded_d = 1'b1;
                    end else if (!second_seeded_q || in_rank > second_rank_q) begin
                        second_idx_d    = count_q;
                        second_val_d    = bus.in_value;
                        second_rank_d   = in_rank;
                        second_seeded_d = 1'b1;
`endif
                    end
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StAccum;
                end
            end
        endcase
        in_ready_d = (state_d == StAccum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            in_ready_q  <= 1'b0;
            count_q     <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            best_rank_q <= '0;
`ifdef EXP_ARGMAX_TOP2_EN
            second_idx_q    <= '0;
            second_val_q    <= '0;
            second_rank_q   <= '0;
            second_seeded_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            best_rank_q <= best_rank_d;
`ifdef EXP_ARGMAX_TOP2_EN
            second_idx_q    <= second_idx_d;
            second_val_q    <= second_val_d;
            second_rank_q   <= second_rank_d;
            second_seeded_q <= second_seeded_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_class = best_idx_q;
    assign bus.out_value = best_val_q;
`ifdef EXP_ARGMAX_TOP2_EN
    assign bus.out_class2 = second_idx_q;
    assign bus.out_value2 = second_val_q;
`endif

endmodule

// File: tb/tb_exp_argmax_classifier.sv
// Scoreboard bench for exp_argmax_classifier; runner-up checks enabled with EXP_ARGMAX_TOP2_EN.
module tb_exp_argmax_classifier;

    localparam int NUM   = 10;
    localparam int W     = 32;
    localparam int IDX_W = 4;

    localparam logic [31:0] E_M2  = 32'h3E0A9555;
    localparam logic [31:0] E2    = 32'h40EC7326;
    localparam logic [31:0] E3    = 32'h41A0AF2F;
    localparam logic [31:0] E5    = 32'h431469C5;
    localparam logic [31:0] QNANV = 32'h7FC00000;
    localparam logic [31:0] NEG1  = 32'hBF800000;
    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] PINF  = 32'h7F800000;
    localparam logic [31:0] MAXF  = 32'h7F7FFFFF;

    typedef logic [31:0] frame_t [NUM];
    typedef struct packed {
        logic [IDX_W-1:0] cls;
        logic [W-1:0]     val;
        logic [IDX_W-1:0] cls2;
        logic [W-1:0]     val2;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    exp_argmax_classifier_if #(
        .EXPONENT_WIDTH(8),
        .MANTISSA_WIDTH(23),
        .NUM_CLASSES(NUM)
    ) bus ();

    exp_argmax_classifier #(
        .EXPONENT_WIDTH(8),
        .MANTISSA_WIDTH(23),
        .NUM_CLASSES(NUM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] tb_rank(input logic [31:0] w);
        if (w[31]) return 31'd0;
        if (w[30:23] == 8'hFF && w[22:0] != 23'd0) return 31'd0;
        return w[30:0];
    endfunction

    function automatic exp_t model(input frame_t f);
        exp_t r;
        int b = 0;
        int s = -1;
        for (int i = 1; i < NUM; i++) if (tb_rank(f[i]) > tb_rank(f[b])) b = i;
        for (int i = 0; i < NUM; i++) begin
            if (i != b && (s < 0 || tb_rank(f[i]) > tb_rank(f[s]))) s = i;
        end
        r.cls  = IDX_W'(b);
        r.val  = f[b];
        r.cls2 = IDX_W'(s);
        r.val2 = f[s];
        return r;
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic drive_beat(input logic [31:0] v);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int gap);
        sb_q.push_back(model(f));
        for (int i = 0; i < NUM; i++) begin
            drive_beat(f[i]);
            if (gap > 0 && i % 3 == 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                    checks++;
                    if (bus.out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_out_valid got %b required 0", bus.out_valid);
                    end
                end
            end
        end
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout got %b required 1", bus.out_valid);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries required 1");
            return;
        end
        e = sb_q.pop_front();
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = c[0];
            bus.in_value = PINF;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_class !== e.cls) begin
                errors++;
                $display("FAIL hold_stable valid=%b ready=%b class=%0d required 1/0/%0d",
                         bus.out_valid, bus.in_ready, bus.out_class, e.cls);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_class !== e.cls) begin
            errors++;
            $display("FAIL out_class got %0d required %0d", bus.out_class, e.cls);
        end
        checks++;
        if (bus.out_value !== e.val) begin
            errors++;
            $display("FAIL out_value got %h required %h", bus.out_value, e.val);
        end
`ifdef EXP_ARGMAX_TOP2_EN
        checks++;
        if (bus.out_class2 !== e.cls2 || bus.out_value2 !== e.val2) begin
            errors++;
            $display("FAIL runner_up got %0d/%h required %0d/%h",
                     bus.out_class2, bus.out_value2, e.cls2, e.val2);
        end
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake valid=%b ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_class !== '0 ||
            bus.out_value !== '0) begin
            errors++;
            $display("FAIL %s ready=%b valid=%b class=%0d value=%h required 0/0/0/0",
                     tag, bus.in_ready, bus.out_valid, bus.out_class, bus.out_value);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_value = E5;
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_zero_outputs("reset_state");
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release got %b required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release ready=%b valid=%b required 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic_frame();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = E_M2;
        f[7] = E5;
        sb_q.push_back(model(f));
        for (int i = 0; i < NUM; i++) begin
            if (i == NUM - 1) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid got %b required 0", bus.out_valid);
                end
            end
            drive_beat(f[i]);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency valid=%b ready=%b required 1/0", bus.out_valid, bus.in_ready);
        end
        collect(0);
    endtask

    task automatic test_ties();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = E2;
        f[2] = E3;
        f[6] = E3;
        send_frame(f, 0);
        collect(0);
    endtask

    task automatic test_nan_neg();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = 32'h0;
        f[0] = QNANV;
        f[1] = NEG1;
        f[4] = ONE;
        send_frame(f, 0);
        collect(0);
        for (int i = 0; i < NUM; i++) f[i] = QNANV;
        send_frame(f, 0);
        collect(0);
    endtask

    task automatic test_backpressure();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = E2;
        f[5] = E5;
        send_frame(f, 0);
        collect(5);
        for (int i = 0; i < NUM; i++) f[i] = E_M2;
        f[9] = E3;
        send_frame(f, 0);
        collect(0);
    endtask

    task automatic test_gaps_and_reset();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = E_M2;
        f[3] = E5;
        send_frame(f, 2);
        collect(0);
        for (int i = 0; i < 5; i++) begin
            drive_beat(E5);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_zero_outputs("mid_frame_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NUM; i++) f[i] = E_M2;
        f[0] = E3;
        send_frame(f, 0);
        collect(0);
    endtask

    task automatic test_back_to_back();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = E2;
        f[1] = MAXF;
        f[3] = PINF;
        send_frame(f, 0);
        collect(0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NUM; i++) begin
                case ($urandom_range(0, 5))
                    0: begin f[i] = $urandom() | 32'h7F800001; f[i][31] = 1'b0; end
                    1: begin f[i] = $urandom(); f[i][31] = 1'b1; end
                    2: f[i] = (i > 0) ? f[i-1] : 32'h0;
                    default: begin f[i] = $urandom(); f[i][31] = 1'b0; end
                endcase
            end
            send_frame(f, k % 2);
            collect(k % 3);
        end
    endtask

`ifdef EXP_ARGMAX_TOP2_EN
    task automatic test_top2();
        frame_t f;
        for (int i = 0; i < NUM; i++) f[i] = E_M2;
        f[0] = E2;
        f[1] = E5;
        f[2] = E3;
        send_frame(f, 0);
        collect(0);
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic_frame();
        test_ties();
        test_nan_neg();
        test_backpressure();
        test_gaps_and_reset();
        test_back_to_back();
`ifdef EXP_ARGMAX_TOP2_EN
        test_top2();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog elapsed time %0t required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
